// File: rtl/multicycle_control_fsm.sv
// Sequencing FSM for a multi-cycle RV32I-subset datapath: drives one strobe set per
// cycle, stretches memory accesses on Mem_Ready_i, traps on illegal opcodes/timeouts.
module multicycle_control_fsm #(
  parameter int CNT_WIDTH  = 32,
  parameter int WAIT_LIMIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           OP_i,
  input  logic                 Zero_i,
  input  logic                 Mem_Ready_i,
  output logic                 PC_Write_o,
  output logic                 PC_Write_Cond_o,
  output logic                 PC_Src_o,
  output logic                 IR_Write_o,
  output logic                 I_or_D_o,
  output logic                 Mem_Read_o,
  output logic                 Mem_Write_o,
  output logic                 Reg_Write_o,
  output logic [1:0]           Mem_to_Reg_o,
  output logic [1:0]           ALU_Src_A_o,
  output logic [1:0]           ALU_Src_B_o,
  output logic [2:0]           ALU_Op_o,
  output logic [2:0]           State_o,
  output logic                 Trap_o,
  output logic [CNT_WIDTH-1:0] Instr_Count_o
);

  // state      | meaning
  // FETCH      | read instruction at PC, PC += 4
  // DECODE     | latch opcode, precompute branch/jump target into ALUOut
  // EXECUTE    | ALU operation / branch resolve / JAL
  // MEM_ACCESS | load or store at ALUOut
  // WRITEBACK  | write rd from ALUOut or MDR
  // TRAP       | illegal opcode or memory timeout, held until reset
  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam int              WAIT_W    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (WAIT_LIMIT > 0) ? WAIT_W'(WAIT_LIMIT - 1) : '0;
  localparam bit              HAS_TIMEOUT = (WAIT_LIMIT > 0);

  state_t               state_q, state_d;
  logic [6:0]           op_q, op_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 trap_q, trap_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 mem_wait;

  // Zero_i is combined with PC_Write_Cond_o in the datapath, not here.
  logic unused_zero;
  assign unused_zero = Zero_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
      trap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      trap_q  <= trap_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    wait_d          = '0;
    trap_d          = trap_q;
    cnt_d           = cnt_q;
    mem_wait        = 1'b0;
    PC_Write_o      = 1'b0;
    PC_Write_Cond_o = 1'b0;
    PC_Src_o        = 1'b0;
    IR_Write_o      = 1'b0;
    I_or_D_o        = 1'b0;
    Mem_Read_o      = 1'b0;
    Mem_Write_o     = 1'b0;
    Reg_Write_o     = 1'b0;
    Mem_to_Reg_o    = 2'b00;
    ALU_Src_A_o     = 2'b00;
    ALU_Src_B_o     = 2'b00;
    ALU_Op_o        = 3'b000;

    case (state_q)
      S_FETCH: begin
        Mem_Read_o  = 1'b1;
        ALU_Src_B_o = 2'b01;
        if (Mem_Ready_i) begin
          IR_Write_o = 1'b1;
          PC_Write_o = 1'b1;
          state_d    = S_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_DECODE: begin
        op_d        = OP_i;
        ALU_Src_A_o = 2'b10;
        ALU_Src_B_o = 2'b10;
        case (OP_i)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI: state_d = S_EXECUTE;
          default: state_d = S_TRAP;
        endcase
      end
      S_EXECUTE: begin
        case (op_q)
          OP_R: begin
            ALU_Src_A_o = 2'b01;
            ALU_Op_o    = 3'b010;
            state_d     = S_WB;
          end
          OP_I: begin
            ALU_Src_A_o = 2'b01;
            ALU_Src_B_o = 2'b10;
            ALU_Op_o    = 3'b011;
            state_d     = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            ALU_Src_A_o = 2'b01;
            ALU_Src_B_o = 2'b10;
            state_d     = S_MEM;
          end
          OP_BRANCH: begin
            ALU_Src_A_o     = 2'b01;
            ALU_Op_o        = 3'b001;
            PC_Write_Cond_o = 1'b1;
            PC_Src_o        = 1'b1;
            state_d         = S_FETCH;
          end
          OP_JAL: begin
            PC_Write_o   = 1'b1;
            PC_Src_o     = 1'b1;
            Reg_Write_o  = 1'b1;
            Mem_to_Reg_o = 2'b10;
            state_d      = S_FETCH;
          end
          OP_LUI: begin
            ALU_Src_A_o = 2'b11;
            ALU_Src_B_o = 2'b10;
            state_d     = S_WB;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        I_or_D_o = 1'b1;
        if (op_q == OP_LOAD || op_q == OP_STORE) begin
          Mem_Read_o  = (op_q == OP_LOAD);
          Mem_Write_o = (op_q == OP_STORE);
          if (Mem_Ready_i) state_d = (op_q == OP_LOAD) ? S_WB : S_FETCH;
          else             mem_wait = 1'b1;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        Reg_Write_o  = 1'b1;
        Mem_to_Reg_o = (op_q == OP_LOAD) ? 2'b01 : 2'b00;
        state_d      = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // Counter only grows while we stay in the same memory state, so entry always sees zero.
    if (mem_wait) begin
      if (HAS_TIMEOUT && wait_q == WAIT_LAST) state_d = S_TRAP;
      else if (wait_q != '1)                  wait_d  = wait_q + WAIT_W'(1);
      else                                    wait_d  = wait_q;
    end

    if (state_d == S_TRAP) trap_d = 1'b1;

    if (state_d == S_FETCH &&
        (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WB))
      cnt_d = cnt_q + CNT_WIDTH'(1);

    if (reset) begin
      PC_Write_o      = 1'b0;
      PC_Write_Cond_o = 1'b0;
      PC_Src_o        = 1'b0;
      IR_Write_o      = 1'b0;
      I_or_D_o        = 1'b0;
      Mem_Read_o      = 1'b0;
      Mem_Write_o     = 1'b0;
      Reg_Write_o     = 1'b0;
      Mem_to_Reg_o    = 2'b00;
      ALU_Src_A_o     = 2'b00;
      ALU_Src_B_o     = 2'b00;
      ALU_Op_o        = 3'b000;
    end
  end

  assign State_o       = state_q;
  assign Trap_o        = trap_q;
  assign Instr_Count_o = cnt_q;

endmodule
